// File: rtl/sched_pkg.sv
// Shared constants and helpers for the k-way priority scheduler.
// Mode selectors and the modulo-N pointer predecessor.
package sched_pkg;

  localparam int SCHED_FIXED = 0;
  localparam int SCHED_RR    = 1;

  function automatic int wrap_prev(input int idx, input int n);
    return (idx == 0) ? n - 1 : idx - 1;
  endfunction

endpackage

// File: rtl/kway_pick.sv
// Combinational K-way picker: first K set bits of pending,
// scanning downward from start and wrapping at N (not 2^W).
module kway_pick
  import sched_pkg::*;
#(
  parameter  int N = 8,
  parameter  int K = 2,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0]        pending,
  input  logic [W-1:0]        start,
  output logic [K-1:0]        valid,
  output logic [K-1:0][W-1:0] idx,
  output logic [N-1:0]        mask
);

  logic [N-1:0] rem;
  logic [W-1:0] pi;
  logic         found;
  int           p;

  always_comb begin
    valid = '0;
    idx   = '0;
    mask  = '0;
    rem   = pending;
    pi    = '0;
    found = 1'b0;
    p     = 0;
    for (int j = 0; j < K; j++) begin
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
        p = int'(start) - i;
        if (p < 0) p = p + N;
        pi = W'(p);
        if (!found && rem[pi]) begin
          found    = 1'b1;
          valid[j] = 1'b1;
          idx[j]   = pi;
          rem[pi]  = 1'b0;
          mask[pi] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/kway_priority_scheduler.sv
// Buffered multi-grant priority scheduler: loads a request vector,
// then drains it K grants per cycle under valid/ready backpressure.
module kway_priority_scheduler
  import sched_pkg::*;
#(
  parameter  int N  = 8,
  parameter  int K  = 2,
  parameter  int RR = 0,
  localparam int W  = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [N-1:0]        req_vec,
  output logic [K-1:0]        grant_valid,
  output logic [K-1:0][W-1:0] grant_dir,
  input  logic                grant_ready,
  output logic                busy
);

  localparam bit       IS_RR = (RR != SCHED_FIXED) && (RR == SCHED_RR);
  localparam [W-1:0]   TOP   = W'(N - 1);

  logic [N-1:0]        pending;
  logic [W-1:0]        ptr;
  logic [W-1:0]        start;
  logic [K-1:0]        pick_valid;
  logic [K-1:0][W-1:0] pick_idx;
  logic [N-1:0]        pick_mask;
  logic [W-1:0]        last_idx;
  logic                adv;

  assign start     = IS_RR ? ptr : TOP;
  assign adv       = !(|grant_valid) || grant_ready;
  assign req_ready = (pending == '0);
  assign busy      = (|pending) || (|grant_valid);

  kway_pick #(.N(N), .K(K)) u_pick (
    .pending (pending),
    .start   (start),
    .valid   (pick_valid),
    .idx     (pick_idx),
    .mask    (pick_mask)
  );

  always_comb begin
    last_idx = pick_idx[0];
    for (int j = 1; j < K; j++) begin
      if (pick_valid[j]) last_idx = pick_idx[j];
    end
  end

  // Load and issue are exclusive: load needs pending == 0, issue needs != 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending     <= '0;
      grant_valid <= '0;
      grant_dir   <= '0;
      ptr         <= TOP;
    end else if (flush) begin
      pending     <= '0;
      grant_valid <= '0;
      grant_dir   <= '0;
      ptr         <= TOP;
    end else begin
      if (adv) begin
        if (|pending) begin
          grant_valid <= pick_valid;
          grant_dir   <= pick_idx;
          pending     <= pending & ~pick_mask;
          if (IS_RR) ptr <= W'(wrap_prev(int'(last_idx), N));
        end else begin
          grant_valid <= '0;
          grant_dir   <= '0;
        end
      end
      if (req_valid && req_ready) pending <= req_vec;
    end
  end

endmodule

// File: tb/tb_kway_priority_scheduler.sv
// Directed bench for kway_priority_scheduler across three configs.
module tb_kway_priority_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   ntest = 0;
  int   nfail = 0;

  always #5 clk = ~clk;

  // A: N=8 K=2 fixed
  logic             flA = 0, rvA = 0, grA = 1, rrA, busyA;
  logic [7:0]       vecA = '0;
  logic [1:0]       gvA;
  logic [1:0][2:0]  gdA;
  // B: N=8 K=1 round-robin
  logic             flB = 0, rvB = 0, grB = 1, rrB, busyB;
  logic [7:0]       vecB = '0;
  logic [0:0]       gvB;
  logic [0:0][2:0]  gdB;
  // C: N=5 K=3 fixed
  logic             flC = 0, rvC = 0, grC = 1, rrC, busyC;
  logic [4:0]       vecC = '0;
  logic [2:0]       gvC;
  logic [2:0][2:0]  gdC;

  kway_priority_scheduler #(.N(8), .K(2), .RR(0)) uA (
    .clk(clk), .rst_n(rst_n), .flush(flA),
    .req_valid(rvA), .req_ready(rrA), .req_vec(vecA),
    .grant_valid(gvA), .grant_dir(gdA),
    .grant_ready(grA), .busy(busyA)
  );

  kway_priority_scheduler #(.N(8), .K(1), .RR(1)) uB (
    .clk(clk), .rst_n(rst_n), .flush(flB),
    .req_valid(rvB), .req_ready(rrB), .req_vec(vecB),
    .grant_valid(gvB), .grant_dir(gdB),
    .grant_ready(grB), .busy(busyB)
  );

  kway_priority_scheduler #(.N(5), .K(3), .RR(0)) uC (
    .clk(clk), .rst_n(rst_n), .flush(flC),
    .req_valid(rvC), .req_ready(rrC), .req_vec(vecC),
    .grant_valid(gvC), .grant_dir(gdC),
    .grant_ready(grC), .busy(busyC)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    ntest++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12 rst_n = 1'b1;
    step();
    check("rst_gv", 32'(gvA), 0);
    check("rst_gd", 32'(gdA), 0);
    check("rst_ready", 32'(rrA), 1);
    check("rst_busy", 32'(busyA), 0);
    check("rst_ptrB", 32'(uB.ptr), 7);

    // 1: B2 -> (7,5) then (4,1)
    rvA = 1; vecA = 8'hB2;
    step();
    rvA = 0;
    check("s1_load_ready", 32'(rrA), 0);
    check("s1_load_gv", 32'(gvA), 0);
    check("s1_load_busy", 32'(busyA), 1);
    step();
    check("s1_i1_gv", 32'(gvA), 3);
    check("s1_i1_d0", 32'(gdA[0]), 7);
    check("s1_i1_d1", 32'(gdA[1]), 5);
    check("s1_i1_ready", 32'(rrA), 0);
    step();
    check("s1_i2_gv", 32'(gvA), 3);
    check("s1_i2_d0", 32'(gdA[0]), 4);
    check("s1_i2_d1", 32'(gdA[1]), 1);
    check("s1_i2_ready", 32'(rrA), 1);
    check("s1_i2_busy", 32'(busyA), 1);
    step();
    check("s1_done_gv", 32'(gvA), 0);
    check("s1_done_busy", 32'(busyA), 0);

    // 2: backpressure holds slots and pending
    rvA = 1; vecA = 8'hB2;
    step();
    rvA = 0;
    step();
    grA = 0;
    check("s2_i1_gv", 32'(gvA), 3);
    for (int c = 0; c < 3; c++) begin
      step();
      check("s2_hold_gv", 32'(gvA), 3);
      check("s2_hold_d0", 32'(gdA[0]), 7);
      check("s2_hold_d1", 32'(gdA[1]), 5);
      check("s2_hold_pend", 32'(uA.pending), 32'h12);
      check("s2_hold_ready", 32'(rrA), 0);
    end
    grA = 1;
    step();
    check("s2_i2_d0", 32'(gdA[0]), 4);
    check("s2_i2_d1", 32'(gdA[1]), 1);
    check("s2_i2_pend", 32'(uA.pending), 0);
    step();
    check("s2_done_gv", 32'(gvA), 0);

    // 3: round-robin K=1
    rvB = 1; vecB = 8'h30;
    step();
    rvB = 0;
    step();
    check("s3_g5_v", 32'(gvB), 1);
    check("s3_g5", 32'(gdB[0]), 5);
    step();
    check("s3_g4", 32'(gdB[0]), 4);
    check("s3_ptr3", 32'(uB.ptr), 3);
    step();
    check("s3_idle_gv", 32'(gvB), 0);
    rvB = 1; vecB = 8'hA1;
    step();
    rvB = 0;
    step();
    check("s3_g0", 32'(gdB[0]), 0);
    check("s3_ptr7", 32'(uB.ptr), 7);
    step();
    check("s3_g7", 32'(gdB[0]), 7);
    step();
    check("s3_g5b", 32'(gdB[0]), 5);
    check("s3_g5b_v", 32'(gvB), 1);
    step();

    // 4: N=5 K=3
    rvC = 1; vecC = 5'b10101;
    step();
    rvC = 0;
    step();
    check("s4_gv", 32'(gvC), 7);
    check("s4_d0", 32'(gdC[0]), 4);
    check("s4_d1", 32'(gdC[1]), 2);
    check("s4_d2", 32'(gdC[2]), 0);
    check("s4_ready", 32'(rrC), 1);
    rvC = 1; vecC = 5'b01000;
    step();
    rvC = 0;
    check("s4_b_gv0", 32'(gvC), 0);
    step();
    check("s4_b_gv", 32'(gvC), 1);
    check("s4_b_d0", 32'(gdC[0]), 3);
    check("s4_b_d1", 32'(gdC[1]), 0);
    check("s4_b_d2", 32'(gdC[2]), 0);
    step();

    // 5: flush mid-burst drops same-cycle vector
    rvA = 1; vecA = 8'hB2;
    step();
    rvA = 0;
    step();
    check("s5_i1_gv", 32'(gvA), 3);
    flA = 1; rvA = 1; vecA = 8'hFF;
    step();
    flA = 0; rvA = 0;
    check("s5_pend", 32'(uA.pending), 0);
    check("s5_gv", 32'(gvA), 0);
    check("s5_ready", 32'(rrA), 1);
    step();
    check("s5_drop_pend", 32'(uA.pending), 0);
    check("s5_drop_busy", 32'(busyA), 0);

    // 6: asynchronous reset mid-burst
    rvA = 1; vecA = 8'hB2;
    step();
    rvA = 0;
    step();
    check("s6_i1_gv", 32'(gvA), 3);
    #2 rst_n = 1'b0;
    #1;
    check("s6_rst_gv", 32'(gvA), 0);
    check("s6_rst_gd", 32'(gdA), 0);
    check("s6_rst_ready", 32'(rrA), 1);
    check("s6_rst_busy", 32'(busyA), 0);
    #1 rst_n = 1'b1;
    rvA = 1; vecA = 8'h01;
    step();
    rvA = 0;
    step();
    check("s6_post_gv", 32'(gvA), 1);
    check("s6_post_d0", 32'(gdA[0]), 0);
    check("s6_post_d1", 32'(gdA[1]), 0);
    step();
    check("s6_post_idle", 32'(busyA), 0);

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule

// File: doc/kway_priority_scheduler.md
Name: kway_priority_scheduler

Overview:
- Registered, parametrised multi-grant priority scheduler for decoder-style request vectors.
- Accepts an N-bit request vector through a valid/ready handshake and holds it in a pending register.
- Drains the pending register by issuing up to K encoded grants per cycle, in fixed-priority (highest index first) or round-robin order.
- Sits between request-vector producers and K parallel consumer ports; generalises the two-output priority decoder to K outputs, adds buffering and backpressure.

Parameters:
- N, 8, request vector width; N >= 2, need not be a power of two.
- K, 2, grant slots per cycle; 1 <= K <= N.
- RR, 0, 0 = fixed priority (index N-1 highest), 1 = round-robin with rotating start pointer.
- W, $clog2(N), grant index width (localparam, not overridable).

Ports:
- clk, in, 1, clock; all state on rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- flush, in, 1, synchronous clear of pending, output slots and pointer.
- req_valid, in, 1, req_vec is valid.
- req_ready, out, 1, scheduler can accept a vector.
- req_vec, in, N, request bits.
- grant_valid, out, K, per-slot valid; slot 0 is the highest priority.
- grant_dir, out, K x W, per-slot granted index.
- grant_ready, in, 1, consumer accepts all slots presented this cycle.
- busy, out, 1, pending != 0 or any grant_valid set.

Behaviour:
- Reset (rst_n low, asynchronous): pending = 0, grant_valid = 0, grant_dir = 0, RR pointer = N-1, req_ready = 1, busy = 0.
- req_ready = (pending == 0), combinational from state. On req_valid && req_ready, pending <= req_vec at the edge. An all-zero req_vec is accepted and ignored.
- Output register advances (adv) when !(|grant_valid) || grant_ready. While not advancing, grant_valid, grant_dir and pending hold and must stay stable.
- On adv, when pending != 0:
  - Select the first min(K, popcount(pending)) set bits in priority order. Slot j gets the j-th selected index.
  - Register the slots, set grant_valid for used slots, clear the selected bits from pending.
- On adv, when pending == 0: grant_valid <= 0.
- Unused slots always drive grant_valid = 0 and grant_dir = 0, never X.
- Priority order:
  - RR=0: descending from N-1.
  - RR=1: descending from the pointer P, wrapping from 0 to N-1.
  - After each issue with RR=1, P <= (last granted index - 1) mod N.
  - The pointer persists across vectors.
- Latency: vector accepted at edge t; first grants visible after edge t+1. A vector with B set bits needs ceil(B/K) issue cycles with no backpressure.
- Pending is never written by load and issue in the same cycle; req_ready is low while bits remain.
- The last issue clears pending, so req_ready rises the cycle after the final slots are registered. The next vector may load while those slots are still waiting on grant_ready.
- flush has priority over load and issue:
  - pending <= 0, grant_valid <= 0, P <= N-1.
  - A req_valid in the same cycle is dropped.
- rst_n asserted mid-burst aborts immediately. After release, the block is idle with outputs at reset values.
- Non-power-of-two N: indices >= N are never produced; the pointer wrap uses N, not 2^W.

Decomposition:
- sched_pkg holds:
  - mode constants SCHED_FIXED = 0 and SCHED_RR = 1;
  - a function computing the wrapped predecessor index modulo N.
- Sub-module kway_pick (combinational):
  - inputs: pending, start pointer;
  - outputs: K valid bits, K indices, and the mask of selected bits.
- Fixed mode ties the start pointer to N-1.
- The top level holds pending, the pointer, the output registers and the handshake.

Test Plan:
1. N=8, K=2, RR=0, req_vec=8'b1011_0010, grant_ready=1 -> slots (7,5) next cycle, then (4,1); req_ready rises with the second issue; busy drops one cycle later.
2. Same vector, grant_ready=0 for 3 cycles after the first issue -> (7,5) held stable, pending stays 8'b0001_0010, then (4,1) issues the cycle after grant_ready rises.
3. N=8, K=1, RR=1:
   - After reset, send 8'h30 -> grants 5, then 4; P=3.
   - Send 8'hA1 -> grants 0, 7, 5 in that order.
4. N=5, K=3, RR=0, req_vec=5'b10101 -> one issue (4,2,0), all valid; then req_vec=5'b01000 -> slot0=3, slots 1 and 2 valid=0 with dir=0.
5. Mid-burst: after the first issue of scenario 1, assert flush with req_valid=1 and req_vec=8'hFF -> next cycle pending=0, grant_valid=0, vector dropped, req_ready=1.
6. Mid-burst, pulse rst_n low asynchronously between edges -> outputs at reset values immediately; the post-release vector 8'h01 yields grant 0 with K=2, slot1 invalid.
